uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Sequences the 8N1 UART receiver: consumes each received byte, acknowledges it with clr_rdy,
//  and frames bytes into checksummed command packets [SYNC][LEN][PAYLOAD x LEN][CSUM].
//  Releases a validated payload to the command consumer through a valid/ready handshake.
//  Sits between the UART receiver and the command decoder.
// PARAMETERS
//  MAX_PAYLOAD  4      maximum payload bytes per packet (1..15)
//  SYNC_BYTE    8'hA5  packet start marker
//  TIMEOUT_CYC  2000   max idle clk cycles between bytes inside a packet (fits TO_W bits)
//  TO_W         12     timeout counter width
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst          in   1                 asynchronous, active-high reset
//  rx_rdy       in   1                 receiver byte-available level
//  rx_data      in   8                 receiver byte, valid while rx_rdy high
//  clr_rdy      out  1                 1-cycle acknowledge to receiver
//  cmd_valid    out  1                 payload available
//  cmd_ready    in   1                 consumer accepts payload
//  cmd_len      out  4                 payload byte count, 1..MAX_PAYLOAD
//  cmd_data     out  8*MAX_PAYLOAD     payload, byte0 in [7:0]; unused bytes are 0
//  err_pulse    out  3                 1-cycle flags {overrun, csum, len/timeout}
//  err_count    out  8                 saturating count of all error events
// BEHAVIOUR
//  - Byte capture: a byte event is rx_rdy & ~rx_rdy_q (rx_rdy_q is a registered copy; reset value 1,
//    so a high level present at reset release is not captured). On a byte event, clr_rdy=1 next cycle.
//  - Reset values: clr_rdy=0, cmd_valid=0, cmd_len=0, cmd_data=0, err_pulse=0, err_count=0, state=HUNT.
//  - FSM states: HUNT, LEN, PAYLOAD, CSUM, HOLD.
//    HUNT:    byte==SYNC_BYTE -> LEN; other bytes are dropped silently (no error).
//    LEN:     byte 1..MAX_PAYLOAD -> store len, csum=byte, idx=0, clear buffer -> PAYLOAD;
//             byte 0 or >MAX_PAYLOAD -> err_pulse[0], HUNT.
//    PAYLOAD: buf[idx]=byte, csum^=byte, idx++; at idx==len-1 -> CSUM.
//    CSUM:    byte==csum -> latch cmd_len/cmd_data, cmd_valid=1 -> HOLD;
//             mismatch -> err_pulse[1], HUNT.
//    HOLD:    cmd_valid held and cmd_len/cmd_data stable until cmd_ready; then cmd_valid=0 -> HUNT.
//             Bytes arriving in HOLD are still acknowledged (clr_rdy), then dropped with err_pulse[2].
//  - Checksum: 8-bit XOR of LEN and all payload bytes.
//  - Latency: cmd_valid rises 1 clk after the CSUM byte event. The handshake completes in any cycle
//    with cmd_valid&cmd_ready, including the first cycle cmd_valid is high.
//  - Timeout: counter resets on every byte event and in HUNT/HOLD. In LEN/PAYLOAD/CSUM, reaching
//    TIMEOUT_CYC -> err_pulse[0], HUNT. If a byte event and the timeout coincide, the byte wins.
//  - A SYNC_BYTE inside a packet is treated as data (no resync).
//  - err_count increments by 1 per cycle with any err_pulse bit set; it saturates at 8'hFF.
//  - rst asserted mid-packet: immediately returns to HUNT with all outputs at reset values;
//    the partial packet is discarded.
// STRUCTURE
//  - Shared package uart_pkg: typedef enum logic [2:0] cmd_state_t {HUNT,LEN,PAYLOAD,CSUM,HOLD};
//    localparam SYNC_BYTE_DEF=8'hA5; error bit index constants ERR_LEN_TO=0, ERR_CSUM=1, ERR_OVR=2.
//  - One sub-module: uart_byte_timer (TO_W-bit counter, clear/enable inputs, expired output).
//  - Remaining logic stays in this file: capture edge detect, FSM, payload buffer, csum register,
//    error counter.
// TESTING
//  - A5 02 11 22 33 (csum 02^11^22=31 is wrong) -> err_pulse[1], no cmd_valid; then A5 02 11 22 31
//    -> cmd_len=2, cmd_data[15:0]=16'h2211.
//  - 00 FF A5 01 7E 7F with cmd_ready=1 -> one cmd_valid cycle, cmd_len=1, cmd_data[7:0]=7E;
//    one clr_rdy pulse per byte (6 total).
//  - A5 05 (MAX_PAYLOAD=4) -> err_pulse[0], state HUNT; a following valid packet is accepted.
//  - A5 03 AA, then stall TIMEOUT_CYC cycles -> err_pulse[0] at exactly TIMEOUT_CYC;
//    a byte arriving in that same cycle instead continues the packet.
//  - Valid packet with cmd_ready=0, then 2 extra bytes -> 2 err_pulse[2], cmd_data unchanged,
//    err_count=2; raise cmd_ready -> cmd_valid drops the next cycle.
//  - Assert rst mid-PAYLOAD -> all outputs 0 asynchronously; after release, rx_rdy held high
//    -> no byte captured.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART command path.
// Used by uart_cmd_ctrl and its byte timer.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    HOLD
  } cmd_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int ERR_LEN_TO = 0;
  localparam int ERR_CSUM   = 1;
  localparam int ERR_OVR    = 2;

endpackage

// File: rtl/uart_byte_timer.sv
// uart_byte_timer: idle-cycle counter between received bytes.
// expired is high in the cycle the idle count reaches its limit.
module uart_byte_timer #(
  parameter int TO_W        = 12,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;

  // A clear in the same cycle always wins over expiry.
  assign expired = en & ~clr & (cnt_q == LAST);

  // Count idle cycles; hold at the limit until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes into [SYNC][LEN][PAYLOAD][CSUM]
// packets and hands checked payloads to the command decoder.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 2000,
  parameter int         TO_W        = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_rdy,
  input  logic [7:0]               rx_data,
  output logic                     clr_rdy,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [3:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] cmd_data,
  output logic [2:0]               err_pulse,
  output logic [7:0]               err_count
);

  localparam int         DW    = 8 * MAX_PAYLOAD;
  localparam logic [7:0] MAX_B = 8'(MAX_PAYLOAD);

  cmd_state_t state_q;
  cmd_state_t state_d;

  logic          rx_rdy_q;
  logic          byte_ev;
  logic [3:0]    len_q;
  logic [3:0]    idx_q;
  logic [7:0]    csum_q;
  logic [DW-1:0] pbuf_q;
  logic [2:0]    err_d;
  logic          ld_len;
  logic          st_byte;
  logic          ld_cmd;
  logic          in_pkt;
  logic          to_clr;
  logic          to_exp;
  logic          len_ok;
  logic          last_byte;
  logic          hs_done;

  assign byte_ev   = rx_rdy & ~rx_rdy_q;
  assign in_pkt    = (state_q == LEN) ||
                     (state_q == PAYLOAD) ||
                     (state_q == CSUM);
  assign to_clr    = byte_ev | ~in_pkt;
  assign len_ok    = (rx_data != 8'd0) && (rx_data <= MAX_B);
  assign last_byte = (idx_q == (len_q - 4'd1));
  assign hs_done   = cmd_valid & cmd_ready;

  uart_byte_timer #(
    .TO_W        (TO_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr),
    .en      (in_pkt),
    .expired (to_exp)
  );

  // Edge-detect rx_rdy; a level held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy_q <= 1'b1;
      clr_rdy  <= 1'b0;
    end else begin
      rx_rdy_q <= rx_rdy;
      clr_rdy  <= byte_ev;
    end
  end

  // Packet state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath strobes and error flags.
  always_comb begin
    state_d = state_q;
    err_d   = '0;
    ld_len  = 1'b0;
    st_byte = 1'b0;
    ld_cmd  = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (byte_ev && rx_data == SYNC_BYTE) begin
          state_d = LEN;
        end
      end
      LEN: begin
        if (byte_ev) begin
          if (len_ok) begin
            ld_len  = 1'b1;
            state_d = PAYLOAD;
          end else begin
            err_d[ERR_LEN_TO] = 1'b1;
            state_d = HUNT;
          end
        end else if (to_exp) begin
          err_d[ERR_LEN_TO] = 1'b1;
          state_d = HUNT;
        end
      end
      PAYLOAD: begin
        if (byte_ev) begin
          st_byte = 1'b1;
          if (last_byte) begin
            state_d = CSUM;
          end
        end else if (to_exp) begin
          err_d[ERR_LEN_TO] = 1'b1;
          state_d = HUNT;
        end
      end
      CSUM: begin
        if (byte_ev) begin
          if (rx_data == csum_q) begin
            ld_cmd  = 1'b1;
            state_d = HOLD;
          end else begin
            err_d[ERR_CSUM] = 1'b1;
            state_d = HUNT;
          end
        end else if (to_exp) begin
          err_d[ERR_LEN_TO] = 1'b1;
          state_d = HUNT;
        end
      end
      HOLD: begin
        if (byte_ev) begin
          err_d[ERR_OVR] = 1'b1;
        end
        if (hs_done) begin
          state_d = HUNT;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // Length, index, checksum and payload buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      idx_q  <= '0;
      csum_q <= '0;
      pbuf_q <= '0;
    end else if (ld_len) begin
      len_q  <= rx_data[3:0];
      idx_q  <= '0;
      csum_q <= rx_data;
      pbuf_q <= '0;
    end else if (st_byte) begin
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        if (idx_q == 4'(i)) begin
          pbuf_q[8*i +: 8] <= rx_data;
        end
      end
      csum_q <= csum_q ^ rx_data;
      idx_q  <= idx_q + 4'd1;
    end
  end

  // Consumer-facing payload and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_len   <= '0;
      cmd_data  <= '0;
    end else if (ld_cmd) begin
      cmd_valid <= 1'b1;
      cmd_len   <= len_q;
      cmd_data  <= pbuf_q;
    end else if (hs_done) begin
      cmd_valid <= 1'b0;
    end
  end

  // Error pulses and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= err_d;
      if (|err_d && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed checks of packet framing, errors,
// timeout, overrun and reset for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

  localparam int TO = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        cmd_ready = 1'b0;
  logic        clr_rdy;
  logic        cmd_valid;
  logic [3:0]  cmd_len;
  logic [31:0] cmd_data;
  logic [2:0]  err_pulse;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int clr_cnt = 0;
  int vld_cnt = 0;
  int e0_cnt = 0;
  int e1_cnt = 0;
  int e2_cnt = 0;

  uart_cmd_ctrl #(
    .MAX_PAYLOAD (4),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO),
    .TO_W        (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .clr_rdy   (clr_rdy),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Event monitor: counts pulses seen at each rising edge.
  always @(posedge clk) begin
    if (clr_rdy) clr_cnt++;
    if (cmd_valid) vld_cnt++;
    if (err_pulse[0]) e0_cnt++;
    if (err_pulse[1]) e1_cnt++;
    if (err_pulse[2]) e2_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic zero_mon();
    clr_cnt = 0;
    vld_cnt = 0;
    e0_cnt  = 0;
    e1_cnt  = 0;
    e2_cnt  = 0;
  endtask

  // Raise rx_rdy, wait for the ack, drop rx_rdy (returns at ack negedge).
  task automatic raise_ack(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (clr_rdy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ack_wait", 32'd0, 32'd1);
    rx_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    raise_ack(b);
    @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_clr", {31'd0, clr_rdy}, 32'd0);
    check("rst_vld", {31'd0, cmd_valid}, 32'd0);
    check("rst_len", {28'd0, cmd_len}, 32'd0);
    check("rst_data", cmd_data, 32'd0);
    check("rst_err", {29'd0, err_pulse}, 32'd0);
    check("rst_ecnt", {24'd0, err_count}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Bad checksum, then a good packet.
    zero_mon();
    send_seq('{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33});
    repeat (2) @(negedge clk);
    check("bad_cs_e1", e1_cnt, 32'd1);
    check("bad_cs_vld", vld_cnt, 32'd0);
    check("bad_cs_ecnt", {24'd0, err_count}, 32'd1);
    send_seq('{8'hA5, 8'h02, 8'h11, 8'h22});
    raise_ack(8'h31);
    check("good_vld", {31'd0, cmd_valid}, 32'd1);
    check("good_len", {28'd0, cmd_len}, 32'd2);
    check("good_data", cmd_data, 32'h0000_2211);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("good_drop", {31'd0, cmd_valid}, 32'd0);
    cmd_ready = 1'b0;
    @(negedge clk);

    // Noise before sync, ready held high.
    zero_mon();
    cmd_ready = 1'b1;
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F});
    repeat (3) @(negedge clk);
    check("noise_clr", clr_cnt, 32'd6);
    check("noise_vld", vld_cnt, 32'd1);
    check("noise_len", {28'd0, cmd_len}, 32'd1);
    check("noise_data", cmd_data, 32'h0000_007E);
    check("noise_ecnt", {24'd0, err_count}, 32'd1);

    // Oversize length, then a good packet.
    zero_mon();
    send_seq('{8'hA5, 8'h05});
    @(negedge clk);
    check("len_e0", e0_cnt, 32'd1);
    check("len_ecnt", {24'd0, err_count}, 32'd2);
    send_seq('{8'hA5, 8'h01, 8'h33, 8'h32});
    repeat (2) @(negedge clk);
    check("len_next_vld", vld_cnt, 32'd1);
    check("len_next_data", cmd_data, 32'h0000_0033);

    // Timeout fires exactly TO idle cycles after the last byte.
    send_seq('{8'hA5, 8'h03});
    raise_ack(8'hAA);
    repeat (TO - 1) @(negedge clk);
    check("to_early", {31'd0, err_pulse[0]}, 32'd0);
    @(negedge clk);
    check("to_exact", {31'd0, err_pulse[0]}, 32'd1);
    check("to_ecnt", {24'd0, err_count}, 32'd3);
    @(negedge clk);
    check("to_once", {31'd0, err_pulse[0]}, 32'd0);

    // A byte landing on the timeout cycle continues the packet.
    zero_mon();
    send_seq('{8'hA5, 8'h03});
    raise_ack(8'hAA);
    repeat (TO - 1) @(negedge clk);
    rx_data = 8'hBB;
    rx_rdy  = 1'b1;
    @(negedge clk);
    check("race_ack", {31'd0, clr_rdy}, 32'd1);
    check("race_noerr", {29'd0, err_pulse}, 32'd0);
    rx_rdy = 1'b0;
    @(negedge clk);
    send_seq('{8'hCC, 8'hDE});
    repeat (3) @(negedge clk);
    check("race_e0", e0_cnt, 32'd0);
    check("race_vld", vld_cnt, 32'd1);
    check("race_len", {28'd0, cmd_len}, 32'd3);
    check("race_data", cmd_data, 32'h00CC_BBAA);
    cmd_ready = 1'b0;

    // Asynchronous reset mid-payload with rx_rdy held high.
    send_seq('{8'hA5, 8'h03, 8'h11});
    rx_data = 8'hA5;
    rx_rdy  = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_vld", {31'd0, cmd_valid}, 32'd0);
    check("arst_len", {28'd0, cmd_len}, 32'd0);
    check("arst_data", cmd_data, 32'd0);
    check("arst_ecnt", {24'd0, err_count}, 32'd0);
    check("arst_err", {29'd0, err_pulse}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    zero_mon();
    repeat (4) @(negedge clk);
    check("arst_nocap", clr_cnt, 32'd0);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Overrun while the consumer stalls.
    zero_mon();
    send_seq('{8'hA5, 8'h01, 8'h44, 8'h45});
    check("ovr_vld", {31'd0, cmd_valid}, 32'd1);
    check("ovr_data0", cmd_data, 32'h0000_0044);
    send_seq('{8'h10, 8'h20});
    check("ovr_e2", e2_cnt, 32'd2);
    check("ovr_clr", clr_cnt, 32'd6);
    check("ovr_data1", cmd_data, 32'h0000_0044);
    check("ovr_ecnt", {24'd0, err_count}, 32'd2);
    check("ovr_hold", {31'd0, cmd_valid}, 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("ovr_drop", {31'd0, cmd_valid}, 32'd0);
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
